// File: rtl/mem_access_ctrl.sv
// Load/store initiator for data_memory: single-word stores and 1-15 word incrementing read bursts.
// Read beat = READ_LATENCY+1 cycles, first response at accept+2+READ_LATENCY; req_ready low while busy, no response backpressure.
module mem_access_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_load_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP_W} state_t;

  localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY);

  state_t     state;
  logic [3:0] beat_cnt;
  logic [3:0] beat_len;
  logic [2:0] wait_cnt;
  logic       accept;

  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_last       <= 1'b0;
      rsp_data       <= '0;
      mem_address    <= '0;
      mem_store_data <= '0;
      mem_memRead    <= 1'b0;
      mem_memWrite   <= 1'b0;
      beat_cnt       <= '0;
      beat_len       <= '0;
      wait_cnt       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state)
        IDLE, RESP_W: begin
          if (accept) begin
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            beat_len    <= (req_len == 4'd0) ? 4'd1 : req_len;
            mem_address <= req_addr;
            busy        <= 1'b1;
            if (req_write) begin
              state          <= WRITE;
              mem_memWrite   <= 1'b1;
              mem_store_data <= req_wdata;
            end else begin
              state       <= READ;
              mem_memRead <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          state        <= RESP_W;
          mem_memWrite <= 1'b0;
          busy         <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_last     <= 1'b1;
          rsp_data     <= '0;
        end
        READ: begin
          // Address is held for the whole beat so the memory sees it for READ_LATENCY+1 cycles.
          if (wait_cnt == LAST_WAIT) begin
            rsp_data  <= mem_load_data;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
            beat_cnt  <= beat_cnt + 4'd1;
            if (beat_cnt == beat_len - 4'd1) begin
              rsp_last    <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
              mem_memRead <= 1'b0;
            end else begin
              mem_address <= mem_address + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Random and directed traffic on two controllers (READ_LATENCY 1 and 0), each against its own memory,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic        rst_n          [2];
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic        req_write      [2];
  logic [15:0] req_addr       [2];
  logic [15:0] req_wdata      [2];
  logic [3:0]  req_len        [2];
  logic        rsp_valid      [2];
  logic [15:0] rsp_data       [2];
  logic        rsp_last       [2];
  logic        busy           [2];
  logic [15:0] mem_address    [2];
  logic [15:0] mem_store_data [2];
  logic        mem_memRead    [2];
  logic        mem_memWrite   [2];

  function automatic logic [15:0] init_val(input int g, input int a);
    logic [15:0] v;
    v = 16'(a * 40503 + g * 7919 + 1);
    if (a >= 16 && a <= 19) v = 16'(160 + a - 16);
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int RL = (g == 0) ? 1 : 0;
    logic [15:0] pmem [65536];
    logic [15:0] ld;

    initial for (int a = 0; a < 65536; a++) pmem[a] = init_val(g, a);
    always @(posedge clk) if (mem_memWrite[g]) pmem[mem_address[g]] <= mem_store_data[g];

    if (RL == 0) begin : g_comb
      assign ld = pmem[mem_address[g]];
    end else begin : g_reg
      always @(posedge clk) ld <= pmem[mem_address[g]];
    end

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(RL)) dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_write     (req_write[g]),
      .req_addr      (req_addr[g]),
      .req_wdata     (req_wdata[g]),
      .req_len       (req_len[g]),
      .rsp_valid     (rsp_valid[g]),
      .rsp_data      (rsp_data[g]),
      .rsp_last      (rsp_last[g]),
      .busy          (busy[g]),
      .mem_address   (mem_address[g]),
      .mem_store_data(mem_store_data[g]),
      .mem_memRead   (mem_memRead[g]),
      .mem_memWrite  (mem_memWrite[g]),
      .mem_load_data (ld)
    );
  end

  // Reference model: a word array plus expected responses stamped with the cycle they must appear in.
  typedef struct {int g; int c; logic [15:0] d; bit last;} exp_t;
  exp_t        eq [$];
  logic [15:0] rmem [2][65536];
  int          rd_start   [2] = '{0, 0};
  int          rd_end     [2] = '{-1, -1};
  logic [15:0] rd_base    [2];
  int          wr_cyc     [2] = '{-1, -1};
  logic [15:0] wr_addr    [2];
  logic [15:0] wr_data    [2];
  int          ready_from [2] = '{0, 0};

  always @(negedge clk) begin
    int          rl, idx, n;
    bit          exp_rd, exp_v;
    logic [15:0] ea;
    for (int g = 0; g < 2; g++) begin
      rl = (g == 0) ? 1 : 0;
      if (!rst_n[g]) begin
        for (int i = eq.size() - 1; i >= 0; i--) if (eq[i].g == g) eq.delete(i);
        rd_end[g]     = -1;
        wr_cyc[g]     = -1;
        ready_from[g] = 0;
        check($sformatf("g%0d_reset_ctrl", g),
              32'({req_ready[g], busy[g], rsp_valid[g], rsp_last[g], mem_memRead[g], mem_memWrite[g]}),
              32'h20);
        check($sformatf("g%0d_reset_data", g), {rsp_data[g], mem_address[g]}, 32'h0);
        check($sformatf("g%0d_reset_sdata", g), 32'(mem_store_data[g]), 32'h0);
      end else begin
        exp_rd = (cyc >= rd_start[g]) && (cyc <= rd_end[g]);
        check($sformatf("g%0d_req_ready", g), 32'(req_ready[g]), 32'(cyc >= ready_from[g]));
        check($sformatf("g%0d_busy", g), 32'(busy[g]), 32'(cyc < ready_from[g]));
        check($sformatf("g%0d_memRead", g), 32'(mem_memRead[g]), 32'(exp_rd));
        check($sformatf("g%0d_memWrite", g), 32'(mem_memWrite[g]), 32'(cyc == wr_cyc[g]));
        if (exp_rd) begin
          ea = rd_base[g] + 16'((cyc - rd_start[g]) / (rl + 1));
          check($sformatf("g%0d_rd_address", g), 32'(mem_address[g]), 32'(ea));
        end
        if (cyc == wr_cyc[g]) begin
          check($sformatf("g%0d_wr_address", g), 32'(mem_address[g]), 32'(wr_addr[g]));
          check($sformatf("g%0d_wr_data", g), 32'(mem_store_data[g]), 32'(wr_data[g]));
        end
        idx = -1;
        for (int i = 0; i < eq.size(); i++) if (eq[i].g == g) begin idx = i; break; end
        exp_v = (idx >= 0) && (eq[idx].c == cyc);
        check($sformatf("g%0d_rsp_valid", g), 32'(rsp_valid[g]), 32'(exp_v));
        if (exp_v) begin
          check($sformatf("g%0d_rsp_data", g), 32'(rsp_data[g]), 32'(eq[idx].d));
          check($sformatf("g%0d_rsp_last", g), 32'(rsp_last[g]), 32'(eq[idx].last));
          eq.delete(idx);
        end
        if (req_valid[g] && req_ready[g]) begin
          if (req_write[g]) begin
            wr_cyc[g]  = cyc + 1;
            wr_addr[g] = req_addr[g];
            wr_data[g] = req_wdata[g];
            rmem[g][req_addr[g]] = req_wdata[g];
            eq.push_back('{g, cyc + 2, 16'h0, 1'b1});
            ready_from[g] = cyc + 2;
          end else begin
            n = (req_len[g] == 4'd0) ? 1 : int'(req_len[g]);
            rd_start[g] = cyc + 1;
            rd_end[g]   = cyc + n * (rl + 1);
            rd_base[g]  = req_addr[g];
            for (int i = 0; i < n; i++)
              eq.push_back('{g, cyc + 2 + rl + i * (rl + 1),
                             rmem[g][16'(int'(req_addr[g]) + i)], (i == n - 1)});
            ready_from[g] = cyc + 1 + n * (rl + 1);
          end
        end
      end
    end
  end

  task automatic send(input int g, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [3:0] len);
    int n = 0;
    req_write[g] = wr;
    req_addr[g]  = a;
    req_wdata[g] = d;
    req_len[g]   = len;
    req_valid[g] = 1'b1;
    while (!req_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("g%0d_accept_timeout", g), 32'(n >= 100), 32'h0);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic random_traffic(input int g, input int count);
    logic [15:0] a;
    for (int t = 0; t < count; t++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      send(g, ($urandom_range(0, 2) == 0), a, 16'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    int seen;
    int waited;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b1; req_valid[g] = 1'b0; req_write[g] = 1'b0;
      req_addr[g] = '0; req_wdata[g] = '0; req_len[g] = '0;
      for (int a = 0; a < 65536; a++) rmem[g][a] = init_val(g, a);
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    idle_cycles(2);

    // Store then read back, a 4-beat preloaded burst, and an address wrap.
    send(0, 1'b1, 16'h0001, 16'h000F, 4'd0);
    send(0, 1'b0, 16'h0001, 16'h0000, 4'd1);
    idle_cycles(4);
    send(0, 1'b0, 16'h0010, 16'h0000, 4'd4);
    idle_cycles(10);
    send(0, 1'b0, 16'hFFFE, 16'h0000, 4'd3);
    idle_cycles(8);

    // Zero length, then requests held back to back through a burst.
    send(0, 1'b0, 16'h0040, 16'h0000, 4'd0);
    send(0, 1'b0, 16'h0020, 16'h0000, 4'd5);
    send(0, 1'b1, 16'h0021, 16'h1234, 4'd0);
    send(0, 1'b0, 16'h0021, 16'h0000, 4'd2);
    idle_cycles(8);

    // Reset in the middle of a 4-beat burst, then a normal read.
    send(0, 1'b0, 16'h0010, 16'h0000, 4'd4);
    seen = 0;
    waited = 0;
    while (seen < 2 && waited < 50) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
      waited++;
    end
    check("g0_midburst_timeout", 32'(waited >= 50), 32'h0);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    idle_cycles(6);
    send(0, 1'b0, 16'h0012, 16'h0000, 4'd2);
    idle_cycles(6);

    // Combinational-read controller.
    send(1, 1'b0, 16'h0010, 16'h0000, 4'd2);
    send(1, 1'b1, 16'hFFFF, 16'hBEEF, 4'd0);
    send(1, 1'b0, 16'hFFFF, 16'h0000, 4'd2);
    idle_cycles(4);

    random_traffic(0, 40);
    random_traffic(1, 40);
    idle_cycles(80);

    check("leftover_responses", 32'(eq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the data_memory port. Drives address, store_data, memRead and memWrite, and captures load_data.
- Accepts single-word store requests and 1-15 word incrementing read bursts over a valid/ready request channel.
- Returns each read word, and one store acknowledge, as a single-cycle response pulse.
- Sits between the load/store stage and data_memory, and hides the memory's read latency from the pipeline.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- READ_LATENCY, 1, number of cycles from the first cycle memRead/address are presented to the cycle load_data is valid. Legal range 0-7; 0 means combinational read.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = read burst.
- req_addr  input  ADDR_W  start address.
- req_wdata  input  DATA_W  store data; ignored for reads.
- req_len  input  4  read beat count; 0 is treated as 1; ignored for stores.
- rsp_valid  output  1  one-cycle pulse per read beat, or per store acknowledge.
- rsp_data  output  DATA_W  read word; 0 on a store acknowledge.
- rsp_last  output  1  final beat of the transaction; qualified by rsp_valid.
- busy  output  1  transaction in progress.
- mem_address  output  ADDR_W  to data_memory address.
- mem_store_data  output  DATA_W  to data_memory store_data.
- mem_memRead  output  1  to data_memory memRead.
- mem_memWrite  output  1  to data_memory memWrite.
- mem_load_data  input  DATA_W  from data_memory load_data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - req_ready=1; busy, rsp_valid, rsp_last, mem_memRead, mem_memWrite = 0.
  - rsp_data, mem_address, mem_store_data = 0.
  - Beat counter and wait counter cleared.
  - An in-flight burst is abandoned; no response is issued for it.
- States: IDLE, WRITE, READ, RESP_W.
- IDLE:
  - req_ready=1, busy=0, mem_memRead and mem_memWrite = 0.
  - mem_address and mem_store_data hold their last driven values.
  - Handshake: the request is accepted on a rising edge where req_valid and req_ready are both 1. At that edge addr, wdata and len (with 0 forced to 1) are latched.
  - Next state is WRITE if req_write=1, otherwise READ.
- WRITE (exactly 1 cycle):
  - mem_memWrite=1, mem_address=latched addr, mem_store_data=latched wdata.
  - Next state RESP_W.
- RESP_W (1 cycle):
  - rsp_valid=1, rsp_last=1, rsp_data=0, mem_memWrite=0.
  - req_ready=1 in this cycle, so a new request is accepted at its closing edge.
  - Next state is IDLE, or WRITE/READ directly if a new request is accepted.
- READ:
  - mem_memRead=1 continuously for the whole burst.
  - mem_address = base + beat_index, modulo 2^ADDR_W (FFFF wraps to 0000).
  - The wait counter runs 0..READ_LATENCY. At the edge where it equals READ_LATENCY, mem_load_data is registered into rsp_data, the beat index increments and the wait counter clears.
  - Each beat therefore takes READ_LATENCY+1 cycles.
  - rsp_valid is high in the cycle after the capture edge; rsp_last=1 on the final beat.
  - After the final capture the state goes to IDLE, so req_ready=1 in the same cycle as the last rsp_valid.
- Latency, request accepted at edge E:
  - Read: first rsp_valid in cycle E+2+READ_LATENCY.
  - Store: mem_memWrite is high in cycle E+1 and the ack is in cycle E+2.
- busy=1 and req_ready=0 in WRITE and READ.
  - A req_valid held high while busy is not accepted. The requester must hold the request stable until it is accepted.
- mem_memRead and mem_memWrite are never both 1.
- No response backpressure: the consumer must take every rsp_valid pulse.

Test Plan:
1. READ_LATENCY=1. Store addr=0x0001, wdata=0x000F; then read addr=0x0001, len=1 -> mem_memWrite high exactly 1 cycle with mem_address=1. Store ack has rsp_last=1, rsp_data=0. Read returns rsp_data=0x000F, rsp_last=1, 3 cycles after acceptance.
2. Memory preloaded with mem[0x10..0x13]=0xA0,0xA1,0xA2,0xA3. Read addr=0x0010, len=4 -> four rsp_valid pulses spaced 2 cycles apart carrying A0..A3. rsp_last only on A3. mem_memRead high throughout.
3. Read addr=0xFFFE, len=3 -> mem_address sequence FFFE, FFFF, 0000. Three responses.
4. req_len=0 -> exactly one beat. req_valid held high during a burst -> the second request is accepted only in the cycle of the final rsp_valid of the first, with no gap.
5. rst_n driven low mid-burst (after beat 2 of 4) -> all outputs go to reset values immediately. No further rsp_valid. The next read after release completes normally.
6. READ_LATENCY=0 build: read len=2 -> responses in consecutive cycles. First response in cycle E+2.
